// File: rtl/rom_dl_router.sv
// Routes ioctl ROM download bytes into per-port SDRAM toggle-handshake write requests,
// with a one-deep pending slot per port, and holds the core in reset until the ROM is loaded.
module rom_dl_router #(
    parameter int unsigned                NUM_PORTS  = 2,
    parameter logic [NUM_PORTS*25-1:0]    PORT_BASE  = {25'h0030000, 25'h0000000},
    parameter logic [NUM_PORTS*25-1:0]    PORT_LIMIT = {25'h00A0000, 25'h00A0000},
    parameter logic [7:0]                 ROM_INDEX  = 8'h00,
    parameter logic [15:0]                RESET_HOLD = 16'hFFFF
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ioctl_downl,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    input  logic                    force_reset,
    output logic [NUM_PORTS-1:0]    port_req,
    input  logic [NUM_PORTS-1:0]    port_ack,
    output logic [NUM_PORTS*23-1:0] port_a,
    output logic [NUM_PORTS*2-1:0]  port_ds,
    output logic [NUM_PORTS*16-1:0] port_d,
    output logic                    port_we,
    output logic                    rom_loaded,
    output logic                    core_reset,
    output logic                    overrun
);

    logic                 wr_q, armed_q, downl_q, seen_q;
    logic                 loaded_q, loaded_d, overrun_q, overrun_d, core_reset_q;
    logic [15:0]          cnt_q, cnt_d;
    logic                 rom_sel, wr_evt;
    logic [NUM_PORTS-1:0] drop_v, busy_v;

    // armed_q masks the first sampled cycle after reset so a held-high strobe is not an edge
    assign rom_sel = ioctl_downl && (ioctl_index == ROM_INDEX);
    assign wr_evt  = rom_sel && ioctl_wr && !wr_q && armed_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [24:0] base, limit;
        logic [23:0] rel;
        logic        hit, idle, drop;
        logic        req_q, req_d, pv_q, pv_d;
        logic [22:0] a_q, a_d, pa_q, pa_d;
        logic [1:0]  ds_q, ds_d, pds_q, pds_d;
        logic [15:0] d_q, d_d, pd_q, pd_d;

        assign base  = PORT_BASE[i*25 +: 25];
        assign limit = PORT_LIMIT[i*25 +: 25];
        assign hit   = wr_evt && (ioctl_addr >= base) && (ioctl_addr < limit);
        assign rel   = 24'(ioctl_addr - base);
        assign idle  = (req_q == port_ack[i]);

        always_comb begin
            req_d = req_q;  pv_d = pv_q;   drop = 1'b0;
            a_d   = a_q;    ds_d = ds_q;   d_d  = d_q;
            pa_d  = pa_q;   pds_d = pds_q; pd_d = pd_q;
            if (idle && pv_q) begin
                // pending goes out first; a same-cycle byte takes the freed slot
                a_d = pa_q;  ds_d = pds_q;  d_d = pd_q;
                req_d = ~req_q;
                pv_d  = hit;
                if (hit) begin
                    pa_d = rel[23:1];  pds_d = {rel[0], ~rel[0]};  pd_d = {ioctl_dout, ioctl_dout};
                end
            end else if (hit) begin
                if (idle) begin
                    a_d = rel[23:1];  ds_d = {rel[0], ~rel[0]};  d_d = {ioctl_dout, ioctl_dout};
                    req_d = ~req_q;
                end else if (!pv_q) begin
                    pa_d = rel[23:1];  pds_d = {rel[0], ~rel[0]};  pd_d = {ioctl_dout, ioctl_dout};
                    pv_d = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                req_q <= 1'b0;  pv_q <= 1'b0;
                a_q   <= '0;    ds_q <= '0;   d_q  <= '0;
                pa_q  <= '0;    pds_q <= '0;  pd_q <= '0;
            end else begin
                req_q <= req_d; pv_q <= pv_d;
                a_q   <= a_d;   ds_q <= ds_d;   d_q  <= d_d;
                pa_q  <= pa_d;  pds_q <= pds_d; pd_q <= pd_d;
            end
        end

        assign port_req[i]          = req_q;
        assign port_a[i*23 +: 23]   = a_q;
        assign port_ds[i*2 +: 2]    = ds_q;
        assign port_d[i*16 +: 16]   = d_q;
        assign drop_v[i]            = drop;
        assign busy_v[i]            = !idle || pv_q;
    end

    assign overrun_d = ((ioctl_downl && !downl_q) ? 1'b0 : overrun_q) | (|drop_v);
    // seen_q can only be set while downloading, so seen_q with downl low means it has fallen
    assign loaded_d  = loaded_q | (seen_q && !ioctl_downl && !(|busy_v));
    assign cnt_d     = (force_reset || !loaded_q) ? RESET_HOLD :
                       (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            armed_q      <= 1'b0;
            downl_q      <= 1'b0;
            seen_q       <= 1'b0;
            loaded_q     <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= RESET_HOLD;
            core_reset_q <= 1'b1;
        end else begin
            wr_q         <= ioctl_wr;
            armed_q      <= 1'b1;
            downl_q      <= ioctl_downl;
            seen_q       <= seen_q | rom_sel;
            loaded_q     <= loaded_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
            core_reset_q <= (cnt_q != 16'd0);
        end
    end

    assign port_we    = downl_q;
    assign rom_loaded = loaded_q;
    assign overrun    = overrun_q;
    assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: directed download scenarios, a behavioural model compared every cycle,
// and literal expectations at the key points.
module tb_rom_dl_router;
    localparam int          NP   = 2;
    localparam logic [15:0] HOLD = 16'd6;
    localparam int          BASE [NP] = '{32'h0000000, 32'h0030000};
    localparam int          LIM  [NP] = '{32'h00A0000, 32'h00A0000};

    logic              clk = 1'b0;
    logic              reset_n, ioctl_downl, ioctl_wr, force_reset;
    logic [7:0]        ioctl_index, ioctl_dout;
    logic [24:0]       ioctl_addr;
    logic [NP-1:0]     port_req, port_ack;
    logic [NP*23-1:0]  port_a;
    logic [NP*2-1:0]   port_ds;
    logic [NP*16-1:0]  port_d;
    logic              port_we, rom_loaded, core_reset, overrun;

    rom_dl_router #(.NUM_PORTS(NP), .RESET_HOLD(HOLD)) dut (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .force_reset(force_reset), .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
        .port_ds(port_ds), .port_d(port_d), .port_we(port_we), .rom_loaded(rom_loaded),
        .core_reset(core_reset), .overrun(overrun));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NP-1:0] m_req = '0, pv = '0;
    logic [22:0]   m_a [NP], pe_a [NP];
    logic [1:0]    m_ds[NP], pe_ds[NP];
    logic [15:0]   m_d [NP], pe_d [NP];
    logic          m_we = 0, m_loaded = 0, m_ovr = 0, m_core_reset = 1;
    logic          seen = 0, prev_wr = 0, prev_downl = 0, armed = 0;
    logic          ev, busy_any, idle, sent;
    int            quiet = 0, rel;
    logic [22:0]   na;
    logic [1:0]    nds;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_req = '0; pv = '0;
            for (int i = 0; i < NP; i++) begin m_a[i] = '0; m_ds[i] = '0; m_d[i] = '0; end
            m_we = 0; m_loaded = 0; m_ovr = 0; m_core_reset = 1; quiet = 0;
            seen = 0; prev_wr = 0; prev_downl = 0; armed = 0;
        end else begin
            ev = armed && ioctl_downl && ioctl_index == 8'h00 && ioctl_wr && !prev_wr;
            busy_any = 0;
            for (int i = 0; i < NP; i++)
                if (m_req[i] != port_ack[i] || pv[i]) busy_any = 1;
            m_core_reset = (quiet < int'(HOLD));
            if (force_reset || !m_loaded) quiet = 0;
            else if (quiet < 100000) quiet++;
            if (seen && !ioctl_downl && !busy_any) m_loaded = 1;
            if (ioctl_downl && ioctl_index == 8'h00) seen = 1;
            if (ioctl_downl && !prev_downl) m_ovr = 0;
            for (int i = 0; i < NP; i++) begin
                idle = (m_req[i] == port_ack[i]);
                sent = 0;
                if (idle && pv[i]) begin
                    m_a[i] = pe_a[i]; m_ds[i] = pe_ds[i]; m_d[i] = pe_d[i];
                    m_req[i] = ~m_req[i]; pv[i] = 0; sent = 1;
                end
                if (ev && int'(ioctl_addr) >= BASE[i] && int'(ioctl_addr) < LIM[i]) begin
                    rel = int'(ioctl_addr) - BASE[i];
                    na  = 23'(rel / 2);
                    nds = (rel % 2 == 1) ? 2'b10 : 2'b01;
                    if (idle && !sent) begin
                        m_a[i] = na; m_ds[i] = nds; m_d[i] = {ioctl_dout, ioctl_dout};
                        m_req[i] = ~m_req[i];
                    end else if (!pv[i]) begin
                        pe_a[i] = na; pe_ds[i] = nds; pe_d[i] = {ioctl_dout, ioctl_dout};
                        pv[i] = 1;
                    end else begin
                        m_ovr = 1;
                    end
                end
            end
            m_we = ioctl_downl; prev_wr = ioctl_wr; prev_downl = ioctl_downl; armed = 1;
        end
    end

    logic chk_en = 0;
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("req%0d", i), port_req[i], m_req[i]);
                chk($sformatf("a%0d", i), port_a[i*23 +: 23], m_a[i]);
                chk($sformatf("ds%0d", i), port_ds[i*2 +: 2], m_ds[i]);
                chk($sformatf("d%0d", i), port_d[i*16 +: 16], m_d[i]);
            end
            chk("we", port_we, m_we);
            chk("rom_loaded", rom_loaded, m_loaded);
            chk("core_reset", core_reset, m_core_reset);
            chk("overrun", overrun, m_ovr);
        end
    end

    // ---------------- stimulus ----------------
    logic [NP-1:0] hold = '0;
    int            ack_dly = 2;
    int            acnt [NP] = '{0, 0};

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (reset_n && !hold[i] && port_req[i] !== port_ack[i]) begin
                acnt[i]++;
                if (acnt[i] >= ack_dly) begin port_ack[i] = port_req[i]; acnt[i] = 0; end
            end else acnt[i] = 0;
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1; tick();
        ioctl_wr = 0; tick();
    endtask

    logic [24:0] burst [8] = '{25'h00100, 25'h30001, 25'h00103, 25'h9FFFF,
                               25'h3FFFE, 25'h00200, 25'h30010, 25'h00005};
    int n;

    initial begin
        reset_n = 0; ioctl_downl = 0; ioctl_wr = 0; force_reset = 0;
        ioctl_index = 0; ioctl_dout = 0; ioctl_addr = 0; port_ack = '0;
        repeat (3) tick();
        chk("rst_req", port_req, 0);
        chk("rst_a", port_a, 0);
        chk("rst_ds_d", {port_ds, port_d}, 0);
        chk("rst_we", port_we, 0);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_overrun", overrun, 0);
        reset_n = 1; chk_en = 1;
        tick();

        // non-ROM index download
        ioctl_downl = 1; ioctl_index = 8'h01; tick();
        wr_byte(25'h00001, 8'h77); wr_byte(25'h30004, 8'h66);
        ioctl_downl = 0; repeat (5) tick();
        chk("idx1_req", port_req, 0);
        chk("idx1_loaded", rom_loaded, 0);

        // ROM download
        ioctl_index = 8'h00; ioctl_downl = 1; tick();
        ioctl_addr = 25'h00001; ioctl_dout = 8'hA5; ioctl_wr = 1; tick();
        chk("b1_req", port_req, 2'b01);
        chk("b1_a0", port_a[22:0], 0);
        chk("b1_ds0", port_ds[1:0], 2'b10);
        chk("b1_d0", port_d[15:0], 16'hA5A5);
        chk("b1_a1", port_a[45:23], 0);
        ioctl_wr = 0; repeat (4) tick();

        ioctl_addr = 25'h30004; ioctl_dout = 8'h3C; ioctl_wr = 1; tick();
        chk("b2_req", port_req, 2'b10);
        chk("b2_a0", port_a[22:0], 23'h18002);
        chk("b2_a1", port_a[45:23], 23'h00002);
        chk("b2_ds", port_ds, 4'b0101);
        chk("b2_d1", port_d[31:16], 16'h3C3C);
        ioctl_wr = 0; repeat (4) tick();

        ioctl_addr = 25'h0A0000; ioctl_wr = 1; tick();
        chk("lim_req", port_req, 2'b10);
        ioctl_wr = 0; repeat (2) tick();

        // reset mid-download with the strobe already high
        ioctl_addr = 25'h00010; ioctl_wr = 1; chk_en = 0; reset_n = 0;
        port_ack = '0; repeat (2) tick();
        reset_n = 1; chk_en = 1; repeat (3) tick();
        chk("rst_mid_req", port_req, 2'b00);
        ioctl_wr = 0; tick();

        // pend and drop on a stalled port 0
        hold[0] = 1;
        wr_byte(25'h00010, 8'h11); wr_byte(25'h00012, 8'h22); wr_byte(25'h00014, 8'h33);
        chk("ovr_set", overrun, 1);
        chk("ovr_req0", port_req[0], 1);
        chk("ovr_hold_a0", port_a[22:0], 23'h8);
        hold[0] = 0; repeat (3) tick();
        chk("pend_issue_a0", port_a[22:0], 23'h9);
        chk("pend_issue_d0", port_d[15:0], 16'h2222);
        chk("pend_issue_req0", port_req[0], 0);
        repeat (4) tick();

        // back-to-back bytes against slow acks
        ack_dly = 3;
        for (int k = 0; k < 8; k++) wr_byte(burst[k], 8'(8'h40 + k));
        ack_dly = 2; repeat (10) tick();

        // end download with an entry still pending
        hold[0] = 1;
        wr_byte(25'h00040, 8'hC1); wr_byte(25'h00042, 8'hC2);
        ioctl_downl = 0; repeat (4) tick();
        chk("loaded_wait", rom_loaded, 0);
        hold[0] = 0;
        n = 0;
        while (!rom_loaded && n < 40) begin tick(); n++; end
        chk("loaded_set", rom_loaded, 1);
        n = 0;
        while (core_reset && n < 100) begin tick(); n++; end
        chk("core_reset_len", n, int'(HOLD) + 1);
        force_reset = 1; tick(); force_reset = 0; tick();
        chk("force_reload", core_reset, 1);
        repeat (int'(HOLD) + 3) tick();
        chk("force_release", core_reset, 0);

        // next download start clears the sticky overrun
        chk("ovr_sticky", overrun, 1);
        ioctl_downl = 1; tick();
        chk("ovr_clear", overrun, 0);
        chk("loaded_sticky", rom_loaded, 1);
        repeat (3) tick();
        ioctl_downl = 0; repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
ROM_DL_ROUTER -- requirements
Module: rom_dl_router

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of SDRAM write ports served (1..4).
REQ-002 Parameter PORT_BASE, default {25'h0030000, 25'h0000000}: packed per-port window base, 25 bits per port, port 0 in LSBs.
REQ-003 Parameter PORT_LIMIT, default {25'h00A0000, 25'h00A0000}: packed per-port exclusive window limit, 25 bits per port.
REQ-004 Parameter ROM_INDEX, default 8'h00: ioctl_index value routed; other indices ignored.
REQ-005 Parameter RESET_HOLD, default 16'hFFFF: core reset hold count in clk_sys cycles.
REQ-006 clk_sys  in  1  single clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 ioctl_downl  in  1  download active.
REQ-009 ioctl_index  in  8  download index.
REQ-010 ioctl_wr  in  1  byte write strobe, level.
REQ-011 ioctl_addr  in  25  byte address.
REQ-012 ioctl_dout  in  8  byte data.
REQ-013 force_reset  in  1  user/menu reset request.
REQ-014 port_req  out  NUM_PORTS  per-port toggle request.
REQ-015 port_ack  in  NUM_PORTS  per-port toggle acknowledge.
REQ-016 port_a  out  NUM_PORTS*23  per-port word address, window-relative.
REQ-017 port_ds  out  NUM_PORTS*2  per-port byte selects.
REQ-018 port_d  out  NUM_PORTS*16  per-port data, byte duplicated.
REQ-019 port_we  out  1  equals ioctl_downl registered.
REQ-020 rom_loaded  out  1  sticky, ROM download complete.
REQ-021 core_reset  out  1  active-high reset to core.
REQ-022 overrun  out  1  sticky, byte dropped.

Function
REQ-023 Write event SHALL be a 0->1 transition of ioctl_wr sampled while ioctl_downl=1 and ioctl_index=ROM_INDEX.
REQ-024 Port i SHALL match when PORT_BASE_i <= ioctl_addr < PORT_LIMIT_i; overlapping windows all match.
REQ-025 For a match, rel = ioctl_addr - PORT_BASE_i; port_a_i = rel[23:1], port_ds_i = {rel[0], ~rel[0]}, port_d_i = {ioctl_dout, ioctl_dout}.
REQ-026 Port idle means port_req_i == port_ack_i; if idle on a write event, port_a/ds/d_i SHALL update and port_req_i toggle on the next clock edge (latency 1).
REQ-027 If busy, the byte SHALL go to a one-entry per-port pending register; issued (outputs updated, req toggled) on the first edge after port becomes idle.
REQ-028 If busy and pending full, the byte SHALL be dropped for that port and overrun set.
REQ-029 Pending issue and a new write event in the same cycle: pending issues, new byte becomes pending (no drop).
REQ-030 Unmatched addresses SHALL produce no request.
REQ-031 Port outputs SHALL hold stable while the port is busy.
REQ-032 overrun SHALL clear on the 0->1 transition of ioctl_downl.
REQ-033 rom_loaded SHALL set once ioctl_downl has fallen after a ROM_INDEX download and all ports are idle with no pending entries; never clears except by reset_n.
REQ-034 Reset counter SHALL load RESET_HOLD while force_reset=1 or rom_loaded=0, else decrement to 0 and stop.
REQ-035 core_reset SHALL be registered (counter != 0).

Reset
REQ-036 reset_n=0 SHALL asynchronously set: port_req=0, pending empty, port_a/ds/d=0, port_we=0, rom_loaded=0, overrun=0, counter=RESET_HOLD, core_reset=1, edge detectors cleared.
REQ-037 reset_n deassertion mid-download SHALL not create a write event from an already-high ioctl_wr.

Verification
REQ-038 Byte 0xA5 at addr 0x00001, ack follows in 2 cycles -> next edge port_req[0]=1, port_a_0=0, port_ds_0=2'b10, port_d_0=16'hA5A5; port 1 unchanged.
REQ-039 Byte at 0x30004 -> port 0 gets a=0x18002, ds=2'b01; port 1 gets a=0x00002, ds=2'b01; both req toggle.
REQ-040 Port 0 ack held for 3 write events -> second pends, third dropped, overrun=1; on ack second issues; next downl rise clears overrun.
REQ-041 Byte at 0xA0000 -> no port_req change.
REQ-042 End download with pending entry -> rom_loaded stays 0 until acked, then 1; core_reset falls after RESET_HOLD+1 cycles; force_reset pulse reloads counter.
REQ-043 Download with ioctl_index=1 -> no requests, rom_loaded stays 0.
